// File: rtl/multi_ch_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_ch_freq_counter
// Description : Counts rising edges on NCH asynchronous inputs over a
//               programmable gate window (in wb_clk_i cycles). All channels
//               are latched together; results are readable through a parallel
//               mux and through a serial shift-out chain (MSB first).
//               Supports one-shot/continuous modes, abort, and per-channel
//               saturation flags.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_ch_freq_counter #(
  parameter  int NCH    = 4,
  parameter  int CNT_W  = 16,
  parameter  int GATE_W = 16,
  parameter  int SYNC_N = 2,
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              rst_n_i,
  input  logic [NCH-1:0]    sig_in,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NCH-1:0]    ovf,
  output logic              busy,
  output logic              done,
  input  logic              sr_load,
  input  logic              sr_shift,
  output logic              sr_out
);

  localparam int               c_chain_w = NCH * CNT_W;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_GATE  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t                       r_state;
  logic [SYNC_N-1:0][NCH-1:0]   r_sync;
  logic [NCH-1:0]               r_prev;
  logic [NCH-1:0]               w_edge;
  logic [GATE_W-1:0]            r_gate_cnt;
  logic [NCH-1:0][CNT_W-1:0]    r_cnt;
  logic [NCH-1:0]               r_sat;
  logic [NCH-1:0][CNT_W-1:0]    r_result;
  logic [NCH-1:0]               r_ovf;
  logic                         r_busy;
  logic                         r_done;
  logic [c_chain_w-1:0]         r_chain;

  // Synchroniser chain per input bit plus a previous-value flop for edge detect
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], sig_in};
      r_prev <= r_sync[SYNC_N-1];
    end
  end

  assign w_edge = r_sync[SYNC_N-1] & ~r_prev;

  // Measurement FSM: arm, count over the gate window, latch results
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_cnt      <= '0;
      r_sat      <= '0;
      r_result   <= '0;
      r_ovf      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // Abort wins over everything; latched results stay as they were
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_ARM;
              r_busy  <= 1'b1;
            end
          end
          S_ARM: begin
            r_cnt      <= '0;
            r_sat      <= '0;
            // A zero gate length still gives a one-cycle window
            r_gate_cnt <= (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
            r_state    <= S_GATE;
          end
          S_GATE: begin
            for (int c = 0; c < NCH; c++) begin
              if (w_edge[c]) begin
                if (r_cnt[c] == c_cnt_max) r_sat[c] <= 1'b1;
                else                       r_cnt[c] <= r_cnt[c] + CNT_W'(1);
              end
            end
            if (r_gate_cnt == '0) r_state    <= S_LATCH;
            else                  r_gate_cnt <= r_gate_cnt - GATE_W'(1);
          end
          S_LATCH: begin
            r_result <= r_cnt;
            r_ovf    <= r_sat;
            r_done   <= 1'b1;
            r_state  <= cont ? S_ARM : S_IDLE;
            r_busy   <= cont;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Serial readback chain, independent of the FSM; shift has priority over load
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_chain <= '0;
    end else if (sr_shift) begin
      r_chain <= r_chain << 1;
    end else if (sr_load) begin
      r_chain <= r_result;
    end
  end

  // Parallel readback mux; out-of-range selects read as zero
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_sel == SEL_W'(c)) rd_data = r_result[c];
    end
  end

  assign ovf    = r_ovf;
  assign busy   = r_busy;
  assign done   = r_done;
  assign sr_out = r_chain[c_chain_w-1];

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_ch_freq_counter
// Description : Scoreboard bench. Random input waveforms are generated up
//               front; each measurement's expected counts are obtained by
//               counting rising transitions of that waveform inside the
//               sampled window. A monitor pops expectations on done, at abort
//               points and for every serial chain bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_ch_freq_counter;

  localparam int NCH    = 3;
  localparam int CNT_W  = 6;
  localparam int GATE_W = 8;
  localparam int SYNC_N = 2;
  localparam int SEL_W  = 2;
  localparam int TOT    = NCH * CNT_W;
  localparam int MAXV   = (1 << CNT_W) - 1;
  localparam int MAXC   = 16000;
  localparam int K_MEAS  = 0;
  localparam int K_ABORT = 1;

  typedef struct {
    int               kind;
    int               due;
    logic [TOT-1:0]   flat;
    logic [NCH-1:0]   ov;
  } exp_t;

  typedef struct {
    int   due;
    logic b;
  } sr_exp_t;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    sig_in;
  logic [GATE_W-1:0] gate_len;
  logic              start, cont, abort;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NCH-1:0]    ovf;
  logic              busy, done;
  logic              sr_load, sr_shift, sr_out;

  logic [NCH-1:0]    wave [0:MAXC-1];
  int                cyc = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  exp_t              sbq[$];
  sr_exp_t           srq[$];
  logic [TOT-1:0]    stim_flat = '0;

  multi_ch_freq_counter #(
    .NCH(NCH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_N(SYNC_N)
  ) dut (
    .wb_clk_i(clk), .rst_n_i(rst_n), .sig_in(sig_in), .gate_len(gate_len),
    .start(start), .cont(cont), .abort(abort), .rd_sel(rd_sel),
    .rd_data(rd_data), .ovf(ovf), .busy(busy), .done(done),
    .sr_load(sr_load), .sr_shift(sr_shift), .sr_out(sr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising clock edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Input driver: the value set after edge k is the one sampled at edge k+1
  initial begin
    sig_in = '0;
    forever begin
      @(negedge clk);
      sig_in = (cyc + 1 < MAXC) ? wave[cyc+1] : '0;
    end
  end

  // Reference: a rising edge first sampled at edge p reaches the counter at
  // edge p+SYNC_N; the window covers edges s+2 .. s+1+L for start sampled at s
  task automatic compute(input int s, input int L, output logic [TOT-1:0] flat,
                         output logic [NCH-1:0] ov);
    int n;
    flat = '0;
    ov   = '0;
    for (int c = 0; c < NCH; c++) begin
      n = 0;
      for (int p = s + 2 - SYNC_N; p <= s + 1 + L - SYNC_N; p++)
        if (wave[p][c] && !wave[p-1][c]) n++;
      ov[c] = (n > MAXV);
      flat[c*CNT_W +: CNT_W] = CNT_W'((n > MAXV) ? MAXV : n);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t           e;
    sr_exp_t        se;
    logic [TOT-1:0] last_flat;
    logic [NCH-1:0] last_ov;
    last_flat = '0;
    last_ov   = '0;
    rd_sel    = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (srq.size() > 0 && srq[0].due == cyc) begin
          se = srq.pop_front();
          chk("sr_out", sr_out, se.b);
        end
        if (done) begin
          if (sbq.size() == 0 || sbq[0].kind != K_MEAS) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("done_cycle", cyc, e.due);
            for (int c = 0; c < NCH; c++) begin
              rd_sel = SEL_W'(c);
              #1 chk("rd_data", rd_data, e.flat[c*CNT_W +: CNT_W]);
            end
            rd_sel = SEL_W'(NCH);
            #1 chk("rd_data_oob", rd_data, 0);
            chk("ovf", ovf, e.ov);
            rd_sel    = '0;
            last_flat = e.flat;
            last_ov   = e.ov;
          end
        end else if (sbq.size() > 0) begin
          if (sbq[0].kind == K_ABORT && cyc == sbq[0].due) begin
            e = sbq.pop_front();
            chk("idle_busy", busy, 0);
            for (int c = 0; c < NCH; c++) begin
              rd_sel = SEL_W'(c);
              #1 chk("kept_result", rd_data, last_flat[c*CNT_W +: CNT_W]);
            end
            chk("kept_ovf", ovf, last_ov);
            rd_sel = '0;
          end else if (sbq[0].kind == K_MEAS && cyc > sbq[0].due) begin
            e = sbq.pop_front();
            chk("done_missing", 0, 1);
          end
        end
      end
    end
  end

  task automatic measure(input int gl, input bit do_abort);
    int   L, s, a;
    exp_t e;
    L = (gl == 0) ? 1 : gl;
    @(negedge clk);
    gate_len = GATE_W'(gl);
    start    = 1'b1;
    s        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    gate_len = GATE_W'($urandom);   // window already captured in ARM
    if (do_abort) begin
      a = s + 2 + $urandom_range(0, L - 1);
      while (cyc < a - 1) @(negedge clk);
      abort  = 1'b1;
      e.kind = K_ABORT;
      e.due  = a;
      e.flat = '0;
      e.ov   = '0;
      sbq.push_back(e);
      @(negedge clk);
      abort = 1'b0;
    end else begin
      compute(s, L, e.flat, e.ov);
      e.kind = K_MEAS;
      e.due  = s + 2 + L;
      sbq.push_back(e);
      stim_flat = e.flat;
      if (L >= 2) begin
        start = 1'b1;               // ignored: FSM is busy
        @(negedge clk);
        start = 1'b0;
      end
      while (cyc < s + 3 + L) @(negedge clk);
    end
  endtask

  initial begin
    int             run, t, s, L, l, gl;
    logic           v;
    exp_t           e;
    sr_exp_t        se;
    logic [TOT-1:0] f;

    for (int c = 0; c < NCH; c++) begin
      t = 0;
      v = 1'b0;
      while (t < MAXC) begin
        run = (c == 0) ? $urandom_range(1, 2) :
              (c == 1) ? $urandom_range(1, 4) : $urandom_range(2, 8);
        for (int k = 0; k < run && t < MAXC; k++) begin
          wave[t][c] = v;
          t++;
        end
        v = ~v;
      end
    end

    rst_n = 1'b0; gate_len = '0; start = 1'b0; cont = 1'b0; abort = 1'b0;
    sr_load = 1'b0; sr_shift = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sr_out", sr_out, 0);
    rst_n = 1'b1;
    while (cyc < 20) @(negedge clk);

    // Directed: minimum window, saturating window, abort mid-gate
    measure(0, 1'b0);
    measure(250, 1'b0);
    measure(100, 1'b1);

    // Randomised measurements
    for (int i = 0; i < 10; i++) begin
      gl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(5, 255);
      measure(gl, ($urandom_range(0, 3) == 0));
    end

    // Continuous mode: three back-to-back windows, cont dropped during the last
    L = $urandom_range(20, 60);
    @(negedge clk);
    gate_len = GATE_W'(L);
    cont     = 1'b1;
    start    = 1'b1;
    s        = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      compute(s + k * (L + 2), L, e.flat, e.ov);
      e.kind = K_MEAS;
      e.due  = s + k * (L + 2) + 2 + L;
      sbq.push_back(e);
      stim_flat = e.flat;
    end
    e.kind = K_ABORT;
    e.due  = s + 2 * (L + 2) + 3 + L;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 2 * (L + 2) + 5) @(negedge clk);
    cont = 1'b0;
    while (cyc < s + 3 * (L + 2) + 3) @(negedge clk);

    // Serial chain: load, shift out with a measurement latching mid-stream,
    // and a load pulse coinciding with a shift
    @(negedge clk);
    sr_load = 1'b1;
    l       = cyc + 1;
    f       = stim_flat;
    for (int j = 0; j < TOT + 3; j++) begin
      se.due = l + j;
      se.b   = (j < TOT) ? f[TOT-1-j] : 1'b0;
      srq.push_back(se);
    end
    @(negedge clk);
    sr_load  = 1'b0;
    sr_shift = 1'b1;
    gate_len = GATE_W'(3);
    start    = 1'b1;
    s        = cyc + 1;
    compute(s, 3, e.flat, e.ov);
    e.kind = K_MEAS;
    e.due  = s + 5;
    sbq.push_back(e);
    stim_flat = e.flat;
    for (int j = 1; j < TOT + 3; j++) begin
      sr_load = (j == 4);
      @(negedge clk);
      start = 1'b0;
    end
    sr_shift = 1'b0;
    sr_load  = 1'b0;
    repeat (3) @(negedge clk);

    // abort and start together in IDLE: abort wins
    start  = 1'b1;
    abort  = 1'b1;
    e.kind = K_ABORT;
    e.due  = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;

    for (int i = 0; i < 600 && (sbq.size() > 0 || srq.size() > 0); i++) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("sr_drained", srq.size(), 0);

    // Asynchronous reset in the middle of a gate window
    @(negedge clk);
    gate_len = GATE_W'(100);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_sr_out", sr_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
